// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage arithmetic units: default width,
// divider function encodings and the divider control states.
package alu_pkg;
  localparam int WIDTH = 32;

  localparam logic DIV_UNSIGNED = 1'b0;
  localparam logic DIV_SIGNED   = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage control path and div_unit.
interface div_unit_if #(parameter int WIDTH = alu_pkg::WIDTH);
  logic             start;
  logic             funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             divz;
  logic             busy;
  logic             done;

  modport master (output start, funct, a, b,
                  input  quot, rem, divz, busy, done);
  modport slave  (input  start, funct, a, b,
                  output quot, rem, divz, busy, done);
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] prem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] prem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // prem < divisor on entry, so shifted < 2*divisor and one extra bit holds the sign
  always_comb begin
    shifted = {prem_i, msb_i};
    trial   = shifted - {1'b0, divisor_i};
    qbit_o  = ~trial[WIDTH];
    prem_o  = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider: WIDTH shift-subtract cycles on magnitudes, then a
// sign fix-up cycle. busy/done are registered views of the control state.
module div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return neg_if(v, v[WIDTH-1]);
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divz_q, divz_d;
  logic             busy_q, done_q;
  logic             signed_op;
  logic [WIDTH-1:0] step_prem;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem_i    (prem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divz_d    = divz_q;
    signed_op = (bus.funct == DIV_SIGNED);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d  = signed_op ? abs_val(bus.a) : bus.a;
          dvs_d  = signed_op ? abs_val(bus.b) : bus.b;
          qneg_d = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rneg_d = signed_op & bus.a[WIDTH-1];
          prem_d = '0;
          cnt_d  = CNT_W'(WIDTH-1);
          // Divide by zero resolves at capture and skips the iteration loop
          if (bus.b == '0) begin
            quot_d  = '1;
            rem_d   = bus.a;
            divz_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        prem_d = step_prem;
        dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quot_d  = neg_if(dvd_q, qneg_q);
        rem_d   = neg_if(prem_q, rneg_q);
        divz_d  = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_q != IDLE);
      done_q  <= (state_q == DONE);
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
    end
  end

  // Working registers are qualified by state and need no reset
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    prem_q <= prem_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.divz = divz_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
